// File: rtl/demux_l2_pkg.sv
// Shared constants and types for the lane mux/demux pair. The 4:1 mux and
// this demux import the same values so their lane numbering stays in lockstep.
package demux_l2_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 2;

    typedef logic [LANE_W-1:0] lane_idx_t;

    localparam lane_idx_t LAST_LANE = 2'd3;

    // What kind of update the lane outputs receive on a given edge.
    typedef enum logic [1:0] {
        PUB_NONE    = 2'd0,
        PUB_FULL    = 2'd1,
        PUB_PARTIAL = 2'd2
    } pub_kind_t;

    // Round-robin successor; the 2-bit width makes 3 wrap to 0.
    function automatic lane_idx_t next_lane(input lane_idx_t cur);
        return cur + 2'd1;
    endfunction

endpackage

// File: rtl/demux_l2_if.sv
// Byte-stream input and four-lane output bundle of the demux. The master side
// is the upstream byte source / downstream lane consumer; the slave side is
// the demux itself.
interface demux_l2_if
    import demux_l2_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);
    logic [WIDTH-1:0] Entrada;
    logic             validEntrada;
    logic [WIDTH-1:0] Salida0;
    logic [WIDTH-1:0] Salida1;
    logic [WIDTH-1:0] Salida2;
    logic [WIDTH-1:0] Salida3;
    logic             validSalida0;
    logic             validSalida1;
    logic             validSalida2;
    logic             validSalida3;
    logic             frame_strobe;
    logic             partial_strobe;

    modport master (
        output Entrada, validEntrada,
        input  Salida0, Salida1, Salida2, Salida3,
        input  validSalida0, validSalida1, validSalida2, validSalida3,
        input  frame_strobe, partial_strobe
    );

    modport slave (
        input  Entrada, validEntrada,
        output Salida0, Salida1, Salida2, Salida3,
        output validSalida0, validSalida1, validSalida2, validSalida3,
        output frame_strobe, partial_strobe
    );
endinterface

// File: rtl/demux_l2_gap_timer.sv
// Idle-gap timer: counts consecutive idle cycles while a frame is partially
// staged and pulses expire_o on the idle cycle where the count would reach
// GAP_LIMIT. GAP_LIMIT = 0 never expires.
module demux_l2_gap_timer #(
    parameter int GAP_LIMIT = 8
) (
    input  logic clk_4f,
    input  logic reset,
    input  logic enable_i,
    input  logic clear_i,
    output logic expire_o
);
    localparam int CNT_W = (GAP_LIMIT > 0) ? $clog2(GAP_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(GAP_LIMIT);
    localparam logic [CNT_W-1:0] CNT_LAST = (GAP_LIMIT > 0) ? CNT_W'(GAP_LIMIT - 1) : '0;
    localparam logic             ARMED    = (GAP_LIMIT > 0) ? 1'b1 : 1'b0;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Expire is combinational so the flush lands on the same edge as the
    // idle cycle that completes the gap; a valid byte (clear) always wins.
    assign expire_o = ARMED & enable_i & ~clear_i & (cnt_q == CNT_LAST);

    // Next idle count: clear on data, restart after expiry, otherwise saturating increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            if (expire_o) begin
                cnt_d = '0;
            end else if (cnt_q < CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Idle counter register.
    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/demux_l2.sv
// 1:4 lane demux. Bytes arriving on the serial stream are staged round-robin;
// a complete frame (or a gap-flushed partial one) is published to held,
// registered lane outputs with per-lane valids and a one-cycle strobe.
module demux_l2
    import demux_l2_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int GAP_LIMIT = 8
) (
    input  logic        clk_4f,
    input  logic        reset,
    demux_l2_if.slave   bus
);
    lane_idx_t        lane_ptr_q, lane_ptr_d;
    logic [WIDTH-1:0] stage_q [3];
    logic [WIDTH-1:0] stage_d [3];
    logic [2:0]       stage_vld_q, stage_vld_d;
    logic [WIDTH-1:0] sal_q [NUM_LANES];
    logic [WIDTH-1:0] sal_d [NUM_LANES];
    logic [3:0]       vld_q, vld_d;
    logic             fs_q, fs_d;
    logic             ps_q, ps_d;
    pub_kind_t        pub_kind_s;
    logic             expire_s;
    logic             gap_en_s;

    assign gap_en_s = (lane_ptr_q != 2'd0) & ~bus.validEntrada;

    demux_l2_gap_timer #(
        .GAP_LIMIT (GAP_LIMIT)
    ) u_gap_timer (
        .clk_4f   (clk_4f),
        .reset    (reset),
        .enable_i (gap_en_s),
        .clear_i  (bus.validEntrada),
        .expire_o (expire_s)
    );

    // Next-state for staging, lane pointer and published lane outputs.
    always_comb begin
        lane_ptr_d  = lane_ptr_q;
        stage_d     = stage_q;
        stage_vld_d = stage_vld_q;
        sal_d       = sal_q;
        vld_d       = vld_q;
        fs_d        = 1'b0;
        ps_d        = 1'b0;
        pub_kind_s  = PUB_NONE;

        if (bus.validEntrada) begin
            lane_ptr_d = next_lane(lane_ptr_q);
            case (lane_ptr_q)
                2'd0: begin stage_d[0] = bus.Entrada; stage_vld_d[0] = 1'b1; end
                2'd1: begin stage_d[1] = bus.Entrada; stage_vld_d[1] = 1'b1; end
                2'd2: begin stage_d[2] = bus.Entrada; stage_vld_d[2] = 1'b1; end
                2'd3: pub_kind_s = PUB_FULL;
                default: pub_kind_s = PUB_NONE;
            endcase
        end else if (expire_s) begin
            pub_kind_s = PUB_PARTIAL;
            lane_ptr_d = 2'd0;
        end else begin
            pub_kind_s = PUB_NONE;
        end

        case (pub_kind_s)
            PUB_FULL: begin
                // The fourth byte goes straight to lane 3 without being staged.
                sal_d[0]    = stage_q[0];
                sal_d[1]    = stage_q[1];
                sal_d[2]    = stage_q[2];
                sal_d[3]    = bus.Entrada;
                vld_d       = 4'b1111;
                fs_d        = 1'b1;
                stage_vld_d = 3'b000;
            end
            PUB_PARTIAL: begin
                // Lanes past the last staged byte read as zero and invalid.
                for (int i = 0; i < 3; i++) begin
                    sal_d[i] = stage_vld_q[i] ? stage_q[i] : '0;
                end
                sal_d[3]    = '0;
                vld_d       = {1'b0, stage_vld_q};
                ps_d        = 1'b1;
                stage_vld_d = 3'b000;
            end
            default: begin
                fs_d = 1'b0;
                ps_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any staged bytes.
    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            lane_ptr_q  <= 2'd0;
            stage_q     <= '{default: '0};
            stage_vld_q <= 3'b000;
            sal_q       <= '{default: '0};
            vld_q       <= 4'b0000;
            fs_q        <= 1'b0;
            ps_q        <= 1'b0;
        end else begin
            lane_ptr_q  <= lane_ptr_d;
            stage_q     <= stage_d;
            stage_vld_q <= stage_vld_d;
            sal_q       <= sal_d;
            vld_q       <= vld_d;
            fs_q        <= fs_d;
            ps_q        <= ps_d;
        end
    end

    assign bus.Salida0        = sal_q[0];
    assign bus.Salida1        = sal_q[1];
    assign bus.Salida2        = sal_q[2];
    assign bus.Salida3        = sal_q[3];
    assign bus.validSalida0   = vld_q[0];
    assign bus.validSalida1   = vld_q[1];
    assign bus.validSalida2   = vld_q[2];
    assign bus.validSalida3   = vld_q[3];
    assign bus.frame_strobe   = fs_q;
    assign bus.partial_strobe = ps_q;

endmodule

// File: tb/tb_demux_l2.sv
// Scoreboard bench for demux_l2: a byte-queue reference model predicts every
// publish (content, valids, kind and the cycle it must appear); a monitor
// compares each strobe against the queue and checks that outputs hold between.
module tb_demux_l2;
    localparam int W   = 8;
    localparam int GAP = 8;

    typedef struct packed {
        logic [31:0]    cyc;
        logic           full;
        logic [3:0]     v;
        logic [4*W-1:0] d;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    demux_l2_if #(.WIDTH(W)) bus ();

    demux_l2 #(.WIDTH(W), .GAP_LIMIT(GAP)) dut (
        .clk_4f (clk),
        .reset  (reset),
        .bus    (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    exp_t       exp_q [$];
    logic [W-1:0] pend [$];
    int         idle_cnt = 0;
    logic [4*W-1:0] last_d = '0;
    logic [3:0]     last_v = 4'b0000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, req);
        end
    endtask

    // Reference model: bytes pile up in a queue; four make a frame, a long
    // enough idle run with bytes pending makes a partial frame.
    task automatic model_step(input bit v, input logic [W-1:0] b);
        exp_t e;
        if (v) begin
            pend.push_back(b);
            idle_cnt = 0;
            if (pend.size() == 4) begin
                e.d    = {pend[3], pend[2], pend[1], pend[0]};
                e.v    = 4'hF;
                e.full = 1'b1;
                e.cyc  = cyc + 1;
                exp_q.push_back(e);
                pend.delete();
            end
        end else if (pend.size() != 0) begin
            idle_cnt++;
            if (GAP > 0 && idle_cnt == GAP) begin
                e.d = '0;
                e.v = 4'b0000;
                for (int i = 0; i < pend.size(); i++) begin
                    e.d[i*W +: W] = pend[i];
                    e.v[i]        = 1'b1;
                end
                e.full = 1'b0;
                e.cyc  = cyc + 1;
                exp_q.push_back(e);
                pend.delete();
                idle_cnt = 0;
            end
        end
    endtask

    task automatic drive(input bit v, input logic [W-1:0] b);
        @(posedge clk);
        #1;
        bus.validEntrada = v;
        bus.Entrada      = v ? b : W'($urandom);
        model_step(v, b);
    endtask

    task automatic send(input logic [W-1:0] b);
        drive(1'b1, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        reset            = 1'b1;
        bus.validEntrada = 1'b0;
        pend.delete();
        idle_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: strobes pop the scoreboard; quiet cycles must hold the last publish.
    always @(negedge clk) begin
        exp_t e;
        logic [4*W-1:0] act_d;
        logic [3:0]     act_v;
        act_d = {bus.Salida3, bus.Salida2, bus.Salida1, bus.Salida0};
        act_v = {bus.validSalida3, bus.validSalida2, bus.validSalida1, bus.validSalida0};
        if (reset) begin
            chk("reset_data",   64'(act_d), 64'd0);
            chk("reset_valid",  64'(act_v), 64'd0);
            chk("reset_strobe", 64'({bus.frame_strobe, bus.partial_strobe}), 64'd0);
            last_d = '0;
            last_v = 4'b0000;
        end else begin
            chk("strobe_excl", 64'(bus.frame_strobe & bus.partial_strobe), 64'd0);
            if (bus.frame_strobe || bus.partial_strobe) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 64'(cyc), 64'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("latency",     64'(cyc), 64'(e.cyc));
                    chk("strobe_kind", 64'({bus.frame_strobe, bus.partial_strobe}),
                        64'({e.full, ~e.full}));
                    chk("lane_data",   64'(act_d), 64'(e.d));
                    chk("lane_valid",  64'(act_v), 64'(e.v));
                    last_d = e.d;
                    last_v = e.v;
                end
            end else begin
                chk("hold_data",  64'(act_d), 64'(last_d));
                chk("hold_valid", 64'(act_v), 64'(last_v));
            end
        end
    end

    initial begin
        int n;
        bus.validEntrada = 1'b0;
        bus.Entrada      = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Full frame, then a back-to-back second frame.
        send(8'hEE); send(8'h01); send(8'hFF); send(8'hFD);
        send(8'hEF); send(8'h02); send(8'h00); send(8'hFE);
        idle(3);

        // Gap shorter than the limit.
        send(8'hEE); send(8'h01); idle(5); send(8'hFF); send(8'hFD);
        idle(2);

        // Partial flush, then the next byte must start at lane 0.
        send(8'hEE); send(8'h01); send(8'hFF); idle(8);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        idle(2);

        // Valid byte on the would-be expiry cycle.
        send(8'hEE); send(8'h01); send(8'hFF); idle(7); send(8'hFD);
        idle(2);

        // Reset mid-frame discards staged bytes.
        send(8'hEE); send(8'h01);
        pulse_reset();
        send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
        idle(2);

        // Random traffic with occasional idle runs long enough to flush.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 9) < 7) send(W'($urandom));
            else idle($urandom_range(1, 10));
        end

        idle(12);
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_l2.md
Name: demux_l2

Overview:
- Downstream neighbour of the 4:1 lane mux.
- Consumes the serialized 8-bit byte stream at clk_4f and distributes bytes round-robin back onto four parallel lanes.
- Each completed 4-byte frame is presented as held, registered lane outputs with per-lane valids for the clk_f domain logic that follows.
- An idle-gap timer flushes incomplete frames so a stalled stream never strands bytes.

Parameters:
- WIDTH, 8, byte width of input and of each lane output.
- GAP_LIMIT, 8, consecutive idle clk_4f cycles mid-frame before a partial-frame flush; 0 disables flushing.

Ports:
- clk_4f  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- Entrada  in  WIDTH  serialized input byte.
- validEntrada  in  1  Entrada carries a byte this cycle.
- Salida0..Salida3  out  WIDTH each  lane outputs; lane 0 = first byte of a frame.
- validSalida0..validSalida3  out  1 each  lane N holds valid data.
- frame_strobe  out  1  one-cycle pulse when lane outputs are updated by a full frame.
- partial_strobe  out  1  one-cycle pulse when lane outputs are updated by a gap flush.

Behaviour:
- Reset (async assert, synchronous to clk_4f on release):
  - All Salida = 0; all validSalida = 0; both strobes = 0.
  - lane_ptr = 0; staging registers and staging valids = 0; idle counter = 0.
- Accept cycle (validEntrada=1):
  - stage[lane_ptr] <= Entrada.
  - lane_ptr increments, wrapping 3 -> 0.
  - Idle counter cleared.
- Full publish: on the edge accepting the byte at lane_ptr=3:
  - Salida0..2 <= stage0..2; Salida3 <= Entrada directly, with no extra stage.
  - All validSalida <= 1; frame_strobe <= 1 for exactly one cycle.
  - Latency: outputs visible one clk_4f edge after the 4th byte's accepting edge.
- Hold rule:
  - Lane outputs and validSalida change only on a publish (full or partial) or on reset.
  - Otherwise they hold indefinitely; the clk_f consumer samples levels.
- Idle cycle (validEntrada=0):
  - lane_ptr=0: no state change; the idle counter stays 0.
  - lane_ptr!=0: idle counter increments, saturating at GAP_LIMIT.
- Partial flush, on the idle cycle where the counter would reach GAP_LIMIT (GAP_LIMIT>0, lane_ptr=k in 1..3):
  - Lanes 0..k-1 <= staged data, valid=1.
  - Lanes k..3 <= 0, valid=0.
  - partial_strobe=1 for one cycle; lane_ptr <= 0; idle counter <= 0; staging valids cleared.
- Simultaneity:
  - A valid byte on a cycle that would otherwise hit GAP_LIMIT is accepted normally; no flush occurs.
  - frame_strobe and partial_strobe are never both 1.
- GAP_LIMIT=0: a partial frame waits indefinitely for more bytes.
- Reset mid-frame: staged bytes are discarded and no strobe fires. The next accepted byte lands in lane 0.
- Width rules:
  - lane_ptr is 2 bits.
  - Idle counter is clog2(GAP_LIMIT+1) bits, minimum 1.
  - No arithmetic on data; bytes pass unmodified.
- Continuous back-to-back valid input: one frame_strobe every 4 clk_4f cycles; no bubbles, no byte loss.

Decomposition:
- Shared package:
  - WIDTH default and lane count constant NUM_LANES=4.
  - Lane index type, 2 bits.
  - Same constants used by the 4:1 mux, so both stages stay in lockstep.
- One natural sub-module: gap_timer.
  - Inputs: clk_4f, reset, enable (lane_ptr!=0 and !validEntrada), clear (validEntrada).
  - Output: expire pulse.
  - Parameterised by GAP_LIMIT.
- Lane/staging logic stays in demux_l2.

Test Plan:
- Full frame: bytes EE, 01, FF, FD on 4 consecutive valid cycles -> one edge later Salida0..3 = EE, 01, FF, FD; validSalida = 1111; frame_strobe high exactly 1 cycle.
- Back-to-back frames with stride: EE,01,FF,FD then EF,02,00,FE -> two frame_strobes 4 cycles apart; second frame outputs EF,02,00,FE; outputs unchanged between strobes.
- Mid-frame gap below limit (GAP_LIMIT=8): EE,01 then 5 idle cycles then FF,FD -> single frame_strobe; lanes EE,01,FF,FD; no partial_strobe.
- Partial flush (GAP_LIMIT=8): EE,01,FF then 8 idle cycles -> partial_strobe on the 8th idle edge; Salida = EE,01,FF,00; validSalida = 1110. Next byte 11 lands in lane 0.
- Byte at limit: 3 bytes, 7 idle cycles, then valid byte FD on the would-be 8th idle cycle -> no flush; full frame with lane 3 = FD.
- Reset mid-frame: EE,01 then reset pulse, then AA,BB,CC,DD -> outputs 0/valids 0 during reset; single frame AA,BB,CC,DD; EE/01 never appear.
